mem_access_ctrl: RTL and testbench

Memory access controller between the multi-cycle datapath's load/store unit and the word-wide data memory (synchronous write, combinational read, single word write-enable, no byte enables). Converts byte, halfword and word load/store requests at byte addresses into word accesses. Implements sub-word stores by read-modify-write, extracts and sign/zero-extends sub-word loads, and flags misaligned or invalid requests without touching memory.

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_access_ctrl_lane_merge_extract.sv | 46 ++++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants for the memory access controller: FSM state codes, SIZE
// encodings and the request legality check.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Misaligned halfword/word or reserved size: request is rejected.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_merge_extract.sv
// Lane logic shared by loads and stores: merges store data into a memory word
// and extracts/extends a load value from it (little-endian lanes).
module lane_merge_extract
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_sdata,
  output logic [DATA_W-1:0] o_merged_c,
  output logic [DATA_W-1:0] o_load_c
);

  logic [4:0]  w_bshift;
  logic [4:0]  w_hshift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_bshift   = {i_lane, 3'b000};
    w_hshift   = {i_lane[1], 4'b0000};
    w_byte     = 8'(i_word >> w_bshift);
    w_half     = 16'(i_word >> w_hshift);
    o_merged_c = i_sdata;
    o_load_c   = i_word;
    // Word-sized requests pass store data straight through as the merged word.
    case (i_size)
      SZ_BYTE: begin
        o_merged_c = (i_word & ~(32'h0000_00FF << w_bshift)) |
                     (32'(i_sdata[7:0]) << w_bshift);
        o_load_c   = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_merged_c = (i_word & ~(32'h0000_FFFF << w_hshift)) |
                     (32'(i_sdata[15:0]) << w_hshift);
        o_load_c   = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_merged_c = i_sdata;
        o_load_c   = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit to word-wide data memory bridge: sub-word stores by
// read-modify-write, sub-word loads with sign/zero extension, error on misalignment.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [ADDR_W+1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WIDTH-1:0]  o_mem_wdi,
  output logic              o_mem_we,
  input  logic [WIDTH-1:0]  i_mem_do
);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W+1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_rdata;
  logic [WIDTH-1:0]  r_wdi;
  logic              r_done;
  logic              r_err;
  logic              r_busy;
  logic              r_we;
  logic              w_word_st;
  logic              w_we_next;
  logic              w_load_wdi;
  logic              w_cap_rdata;
  logic [WIDTH-1:0]  w_merged;
  logic [WIDTH-1:0]  w_load;

  lane_merge_extract u_lane (
    .i_word     (i_mem_do),
    .i_size     (r_size),
    .i_lane     (r_addr[1:0]),
    .i_signed   (r_signed),
    .i_sdata    (r_wdata),
    .o_merged_c (w_merged),
    .o_load_c   (w_load)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the decodes that feed the registered outputs.
  always_comb begin
    w_next      = r_state;
    w_word_st   = r_wr && (r_size == SZ_WORD);
    w_we_next   = 1'b0;
    w_load_wdi  = 1'b0;
    w_cap_rdata = 1'b0;
    case (r_state)
      S_IDLE:   if (i_req) w_next = S_CHECK;
      S_CHECK:  w_next = is_bad_req(r_size, r_addr[1:0]) ? S_FAIL : S_ACCESS;
      S_ACCESS: w_next = (r_wr && !w_word_st) ? S_WRITE : S_DONE;
      S_WRITE:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_FAIL:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    w_we_next   = ((w_next == S_ACCESS) && w_word_st) || (w_next == S_WRITE);
    w_load_wdi  = ((r_state == S_CHECK) && (w_next == S_ACCESS) && w_word_st) ||
                  ((r_state == S_ACCESS) && (w_next == S_WRITE));
    w_cap_rdata = (r_state == S_ACCESS) && !r_wr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_wdi    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_req) begin
        r_wr     <= i_wr;
        r_size   <= i_size;
        r_signed <= i_signed;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
      end
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE) || (w_next == S_FAIL);
      r_err  <= (w_next == S_FAIL);
      r_we   <= w_we_next;
      if (w_load_wdi)  r_wdi   <= w_merged;
      if (w_cap_rdata) r_rdata <= w_load;
    end
  end

  // Write enable is gated by reset so no write lands on a reset edge.
  assign o_mem_we   = r_we & ~i_rst;
  assign o_mem_wdi  = r_wdi;
  assign o_mem_addr = r_addr[ADDR_W+1:2];
  assign o_rdata    = r_rdata;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a word memory model and a
// scoreboard of expected completions.
module tb_mem_access_ctrl;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, req, wr, sgn;
  logic [1:0]        size;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata, rdata, mem_wdi, mem_do;
  logic              done, err, busy, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;

  always @(posedge clk) begin
    if (mem_we)      mem[mem_addr] <= mem_wdi;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_do = mem[mem_addr];

  mem_access_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_size(size),
    .i_signed(sgn), .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata),
    .o_done(done), .o_err(err), .o_busy(busy), .o_mem_addr(mem_addr),
    .o_mem_wdi(mem_wdi), .o_mem_we(mem_we), .i_mem_do(mem_do)
  );

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    bit          chk_rd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata;

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Drives one request, records its expectation, and observes the completion.
  task automatic send(input logic w, input logic [1:0] sz, input logic s,
                      input logic [ADDR_W+1:0] a, input logic [31:0] d, input exp_t e,
                      output int lat, output logic er, output logic [31:0] rd, output int wes);
    sb.push_back(e);
    @(negedge clk); req = 1'b1; wr = w; size = sz; sgn = s; addr = a; wdata = d;
    @(posedge clk);
    lat = -1; er = 1'b0; rd = '0; wes = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); req = 1'b0;
      if (mem_we) wes++;
      if (done) begin lat = k; er = err; rd = rdata; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdata !== 32'h0)    begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_we !== 1'b0)    begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== '0)    begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdi !== 32'h0)  begin failures++; $display("FAIL reset_wdi got=%h exp=0", mem_wdi); end
  endtask

  task automatic test_word_store_load();
    int lat, wes; logic er; logic [31:0] rd; exp_t e;
    send(1'b1, W, 1'b0, 7'h08, 32'hDEADBEEF, '{lat:3, err:1'b0, rdata:32'h0, chk_rd:1'b0}, lat, er, rd, wes);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL wst_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (er !== e.err)  begin failures++; $display("FAIL wst_err got=%b exp=%b", er, e.err); end
    checks++; if (wes !== 1)     begin failures++; $display("FAIL wst_we_cycles got=%0d exp=1", wes); end
    checks++; if (mem[2] !== 32'hDEADBEEF) begin failures++; $display("FAIL wst_mem got=%h exp=deadbeef", mem[2]); end
    send(1'b0, W, 1'b0, 7'h08, 32'h0, '{lat:3, err:1'b0, rdata:32'hDEADBEEF, chk_rd:1'b1}, lat, er, rd, wes);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL wld_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (er !== e.err)  begin failures++; $display("FAIL wld_err got=%b exp=%b", er, e.err); end
    checks++; if (e.chk_rd && rd !== e.rdata) begin failures++; $display("FAIL wld_rdata got=%h exp=%h", rd, e.rdata); end
    last_rdata = e.rdata;
  endtask

  task automatic test_byte_rmw();
    int lat, wes; logic er; logic [31:0] rd; exp_t e;
    preload(5'd2, 32'h11223344);
    send(1'b1, B, 1'b0, 7'h09, 32'h000000AB, '{lat:4, err:1'b0, rdata:32'h0, chk_rd:1'b0}, lat, er, rd, wes);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL rmw_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (er !== e.err)  begin failures++; $display("FAIL rmw_err got=%b exp=%b", er, e.err); end
    checks++; if (wes !== 1)     begin failures++; $display("FAIL rmw_we_cycles got=%0d exp=1", wes); end
    checks++; if (mem[2] !== 32'h1122AB44) begin failures++; $display("FAIL rmw_mem got=%h exp=1122ab44", mem[2]); end
  endtask

  task automatic test_signed_loads();
    logic [6:0]  ta [6] = '{7'h02, 7'h02, 7'h01, 7'h02, 7'h00, 7'h03};
    logic [1:0]  tz [6] = '{B, H, B, H, H, B};
    logic        ts [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tx [6] = '{32'hFFFFFFFF, 32'h000080FF, 32'h0000007F,
                            32'hFFFF80FF, 32'h00007F01, 32'h00000080};
    int lat, wes; logic er; logic [31:0] rd; exp_t e;
    preload(5'd0, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      send(1'b0, tz[i], ts[i], ta[i], 32'h0, '{lat:3, err:1'b0, rdata:tx[i], chk_rd:1'b1}, lat, er, rd, wes);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL ld%0d_lat got=%0d exp=%0d", i, lat, e.lat); end
      checks++; if (e.chk_rd && rd !== e.rdata) begin failures++; $display("FAIL ld%0d_rdata got=%h exp=%h", i, rd, e.rdata); end
      last_rdata = e.rdata;
    end
  endtask

  task automatic test_errors();
    logic       tw [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] tz [3] = '{W, H, R};
    logic [6:0] ta [3] = '{7'h06, 7'h03, 7'h00};
    int lat, wes; logic er; logic [31:0] rd; exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(tw[i], tz[i], 1'b0, ta[i], 32'hA5A5A5A5, '{lat:2, err:1'b1, rdata:last_rdata, chk_rd:1'b1}, lat, er, rd, wes);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin failures++; $display("FAIL err%0d_lat got=%0d exp=%0d", i, lat, e.lat); end
      checks++; if (er !== e.err)  begin failures++; $display("FAIL err%0d_err got=%b exp=%b", i, er, e.err); end
      checks++; if (wes !== 0)     begin failures++; $display("FAIL err%0d_we_cycles got=%0d exp=0", i, wes); end
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL err%0d_rdata got=%h exp=%h", i, rd, e.rdata); end
    end
    checks++; if (mem[0] !== 32'h80FF7F01) begin failures++; $display("FAIL err_mem got=%h exp=80ff7f01", mem[0]); end
  endtask

  task automatic test_reset_mid_rmw();
    preload(5'd1, 32'hCAFEF00D);
    @(negedge clk); req = 1'b1; wr = 1'b1; size = B; sgn = 1'b0; addr = 7'h04; wdata = 32'h55;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_write_phase got=%b exp=1", mem_we); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem[1] !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_mem got=%h exp=cafef00d", mem[1]); end
    checks++; if ({rdata, done, err, busy, mem_we} !== 36'h0) begin failures++; $display("FAIL rst_outs got=%h/%b%b%b%b exp=0", rdata, done, err, busy, mem_we); end
    checks++; if ({mem_addr, mem_wdi} !== '0) begin failures++; $display("FAIL rst_mem_if got=%h/%h exp=0", mem_addr, mem_wdi); end
    rst = 1'b0;
    last_rdata = 32'h0;
  endtask

  task automatic test_busy_overlap();
    int nd, lat, wes; logic [31:0] rd; exp_t e;
    preload(5'd4, 32'h0);
    sb.push_back('{lat:3, err:1'b0, rdata:32'h1122AB44, chk_rd:1'b1});
    @(negedge clk); req = 1'b1; wr = 1'b0; size = W; sgn = 1'b0; addr = 7'h08; wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovl_busy got=%b exp=1", busy); end
    req = 1'b1; wr = 1'b1; size = W; addr = 7'h10; wdata = 32'h12345678;
    nd = 0; lat = -1; rd = '0; wes = 0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk); req = 1'b0;
      if (mem_we) wes++;
      if (done) begin nd++; if (lat < 0) begin lat = k; rd = rdata; end end
    end
    e = sb.pop_front();
    checks++; if (nd !== 1)      begin failures++; $display("FAIL ovl_done_count got=%0d exp=1", nd); end
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL ovl_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (rd !== e.rdata) begin failures++; $display("FAIL ovl_rdata got=%h exp=%h", rd, e.rdata); end
    checks++; if (wes !== 0 || mem[4] !== 32'h0) begin failures++; $display("FAIL ovl_no_write got=%0d/%h exp=0/0", wes, mem[4]); end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sgn = 1'b0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; last_rdata = '0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_signed_loads();
    test_errors();
    test_reset_mid_rmw();
    test_busy_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
